// File: rtl/switch_xbar_rr_if.sv
// switch_xbar_rr_if: input-side and output-side req/ack bundle of the crossbar
interface switch_xbar_rr_if #(
  parameter int NUM_PORTS  = 5,
  parameter int DATA_WIDTH = 18,
  parameter int DEST_WIDTH = $clog2(NUM_PORTS)
);
  logic [NUM_PORTS-1:0]            in_req;
  logic [NUM_PORTS*DEST_WIDTH-1:0] in_dest;
  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data;
  logic [NUM_PORTS-1:0]            in_last;
  logic [NUM_PORTS-1:0]            in_ack;
  logic [NUM_PORTS-1:0]            out_req;
  logic [NUM_PORTS*DATA_WIDTH-1:0] out_data;
  logic [NUM_PORTS-1:0]            out_last;
  logic [NUM_PORTS-1:0]            out_ack;
  logic                            err_bad_dest;
  modport master (
    output in_req, in_dest, in_data, in_last, out_ack,
    input  in_ack, out_req, out_data, out_last, err_bad_dest
  );
  modport slave (
    input  in_req, in_dest, in_data, in_last, out_ack,
    output in_ack, out_req, out_data, out_last, err_bad_dest
  );
endinterface

// File: rtl/switch_xbar_rr.sv
// switch_xbar_rr: registered N-port crossbar, per-output round-robin arbiter
// with wormhole locking and a one-flit output register.
module switch_xbar_rr #(
  parameter int NUM_PORTS  = 5,
  parameter int DATA_WIDTH = 18,
  localparam int DEST_WIDTH = $clog2(NUM_PORTS)
) (
  input logic clk,
  input logic rst,
  switch_xbar_rr_if.slave bus
);
  logic [NUM_PORTS-1:0]            lock;
  logic [DEST_WIDTH-1:0]           owner  [NUM_PORTS];
  logic [DEST_WIDTH-1:0]           rr_ptr [NUM_PORTS];
  logic [NUM_PORTS-1:0]            oreq, olast;
  logic [NUM_PORTS*DATA_WIDTH-1:0] odata;
  logic                            err;
  logic [DEST_WIDTH-1:0]           win    [NUM_PORTS];
  logic [NUM_PORTS-1:0]            win_ok, take, owned, ack;
  logic                            bad;
  logic [DEST_WIDTH-1:0]           idx;
  always_comb begin
    owned  = '0;
    win_ok = '0;
    take   = '0;
    ack    = '0;
    bad    = 1'b0;
    idx    = '0;
    for (int o = 0; o < NUM_PORTS; o++) win[o] = '0;
    for (int o = 0; o < NUM_PORTS; o++) if (lock[o]) owned[owner[o]] = 1'b1;
    // inputs mid-packet on some output are excluded from every other arbiter
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (lock[o]) begin
        win[o]    = owner[o];
        win_ok[o] = bus.in_req[owner[o]];
      end else begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          idx = DEST_WIDTH'((int'(rr_ptr[o]) + k) % NUM_PORTS);
          if (!win_ok[o] && bus.in_req[idx] && !owned[idx] &&
              int'(bus.in_dest[int'(idx)*DEST_WIDTH +: DEST_WIDTH]) == o) begin
            win_ok[o] = 1'b1;
            win[o]    = idx;
          end
        end
      end
      take[o] = win_ok[o] && (!oreq[o] || bus.out_ack[o]) && !rst;
      if (take[o]) ack[win[o]] = 1'b1;
    end
    for (int p = 0; p < NUM_PORTS; p++)
      if (bus.in_req[p] && int'(bus.in_dest[p*DEST_WIDTH +: DEST_WIDTH]) >= NUM_PORTS) bad = 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock  <= '0;
      oreq  <= '0;
      olast <= '0;
      odata <= '0;
      err   <= 1'b0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        owner[o]  <= '0;
        rr_ptr[o] <= '0;
      end
    end else begin
      err <= err | bad;
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (take[o]) begin
          oreq[o] <= 1'b1;
          odata[o*DATA_WIDTH +: DATA_WIDTH] <= bus.in_data[int'(win[o])*DATA_WIDTH +: DATA_WIDTH];
          olast[o] <= bus.in_last[win[o]];
          if (bus.in_last[win[o]]) begin
            lock[o]   <= 1'b0;
            rr_ptr[o] <= (int'(win[o]) == NUM_PORTS - 1) ? '0 : win[o] + 1'b1;
          end else begin
            lock[o]  <= 1'b1;
            owner[o] <= win[o];
          end
        end else if (bus.out_ack[o]) begin
          oreq[o] <= 1'b0;
        end
      end
    end
  end
  assign bus.in_ack       = ack;
  assign bus.out_req      = oreq;
  assign bus.out_data     = odata;
  assign bus.out_last     = olast;
  assign bus.err_bad_dest = err;
endmodule
